oflow_mem_buffer_arbiter: RTL and testbench

- Shares the single dual-offset history-frame memory buffer (two offsets per access, one write-enable) between NUM_REQ requesters, e.g. PE lanes and the frame writer.
- Grants whole bursts, with write priority and round-robin fairness inside each class.
- Drives the buffer's frame/offset/we controls from registers and tags returned read data with the owning requester.
- Sits between the core FSM/PE cluster and the memory-buffer wrapper.

---
 rtl/oflow_mem_arb_pkg.sv | 22 ++
 rtl/oflow_rr_picker.sv | 36 +++
 rtl/oflow_mem_buffer_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_oflow_mem_buffer_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oflow_mem_arb_pkg.sv
// Shared types and default sizing for the history-frame buffer arbiter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package oflow_mem_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam int DEF_NUM_REQ       = 4;
   localparam int DEF_FRAME_W       = 5;
   localparam int DEF_OFFSET_W      = 7;
   localparam int DEF_RD_LAT        = 1;
   localparam int DEF_MAX_WR_STREAK = 3;

   // Round-robin successor of a requester index, wrapping modulo n.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/oflow_rr_picker.sv
// Round-robin one-hot picker: first set request at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a pick is consumed.
module oflow_rr_picker #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_vec,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     pick_oh,
   output logic [IDX_W-1:0] pick_idx,
   output logic             pick_vld
);

   // Scan N candidates starting at ptr; the first requesting one wins.
   always_comb begin
      int               j;
      logic [IDX_W-1:0] jj;
      pick_oh  = '0;
      pick_idx = '0;
      pick_vld = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) begin
            j = j - N;
         end
         jj = j[IDX_W-1:0];
         if (!pick_vld && req_vec[jj]) begin
            pick_vld     = 1'b1;
            pick_oh[jj]  = 1'b1;
            pick_idx     = jj;
         end
      end
   end

endmodule

// File: rtl/oflow_mem_buffer_arbiter.sv
// Burst arbiter sharing the dual-offset history-frame buffer; writes first, RR per class.
// Latency: grant 1 cycle after request; mem_* 1 cycle after ack; read tag RD_LAT+1 after ack.
// Backpressure: requesters hold req until their last beat is acked; ack = gnt & req.
module oflow_mem_buffer_arbiter
   import oflow_mem_arb_pkg::*;
#(
   parameter int NUM_REQ       = DEF_NUM_REQ,
   parameter int FRAME_W       = DEF_FRAME_W,
   parameter int OFFSET_W      = DEF_OFFSET_W,
   parameter int RD_LAT        = DEF_RD_LAT,
   parameter int MAX_WR_STREAK = DEF_MAX_WR_STREAK
) (
   input  logic                          clk,
   input  logic                          reset_N,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*FRAME_W-1:0]    req_frame,
   input  logic [NUM_REQ*OFFSET_W-1:0]   req_offset_0,
   input  logic [NUM_REQ*OFFSET_W-1:0]   req_offset_1,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            ack,
   output logic [FRAME_W-1:0]            mem_frame_num,
   output logic [OFFSET_W-1:0]           mem_offset_0,
   output logic [OFFSET_W-1:0]           mem_offset_1,
   output logic                          mem_we,
   output logic                          rd_valid,
   output logic [$clog2(NUM_REQ)-1:0]    rd_owner,
   output logic                          busy
);

   localparam int IDX_W    = $clog2(NUM_REQ);
   localparam int STREAK_W = $clog2(MAX_WR_STREAK + 1);

   arb_state_e           state_q;
   arb_state_e           state_d;
   logic                 grant_now;
   logic [IDX_W-1:0]     owner_q;
   logic [IDX_W-1:0]     rd_ptr_q;
   logic [IDX_W-1:0]     wr_ptr_q;
   logic [STREAK_W-1:0]  wr_streak_q;

   logic [NUM_REQ-1:0]   wr_req;
   logic [NUM_REQ-1:0]   rd_req;
   logic [NUM_REQ-1:0]   rd_pick_oh;
   logic [NUM_REQ-1:0]   wr_pick_oh;
   logic [NUM_REQ-1:0]   win_oh;
   logic [IDX_W-1:0]     rd_pick_idx;
   logic [IDX_W-1:0]     wr_pick_idx;
   logic [IDX_W-1:0]     win_idx;
   logic                 rd_pick_vld;
   logic                 wr_pick_vld;
   logic                 pick_write;
   logic                 streak_full;

   logic                 own_req;
   logic                 own_we;
   logic                 own_last;
   logic [FRAME_W-1:0]   own_frame;
   logic [OFFSET_W-1:0]  own_off_0;
   logic [OFFSET_W-1:0]  own_off_1;
   logic                 beat_ack;
   logic                 rd_push;

   logic [RD_LAT:0]      rd_vld_sr;
   logic [IDX_W-1:0]     rd_id_sr [RD_LAT+1];

   assign wr_req = req & req_we;
   assign rd_req = req & ~req_we;

   oflow_rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rd_pick (
      .req_vec  (rd_req),
      .ptr      (rd_ptr_q),
      .pick_oh  (rd_pick_oh),
      .pick_idx (rd_pick_idx),
      .pick_vld (rd_pick_vld)
   );

   oflow_rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_wr_pick (
      .req_vec  (wr_req),
      .ptr      (wr_ptr_q),
      .pick_oh  (wr_pick_oh),
      .pick_idx (wr_pick_idx),
      .pick_vld (wr_pick_vld)
   );

   // Writes win unless they have used up their streak while a read waits.
   assign streak_full = (wr_streak_q == STREAK_W'(MAX_WR_STREAK));
   assign pick_write  = wr_pick_vld && !(streak_full && rd_pick_vld);
   assign win_oh      = pick_write ? wr_pick_oh  : rd_pick_oh;
   assign win_idx     = pick_write ? wr_pick_idx : rd_pick_idx;

   // Fields of the current burst owner.
   assign own_req   = req[owner_q];
   assign own_we    = req_we[owner_q];
   assign own_last  = req_last[owner_q];
   assign own_frame = req_frame[int'(owner_q)*FRAME_W +: FRAME_W];
   assign own_off_0 = req_offset_0[int'(owner_q)*OFFSET_W +: OFFSET_W];
   assign own_off_1 = req_offset_1[int'(owner_q)*OFFSET_W +: OFFSET_W];

   assign ack      = gnt & req;
   assign beat_ack = |ack;
   assign rd_push  = beat_ack && !own_we;
   assign busy     = (state_q == BURST);
   assign rd_valid = rd_vld_sr[RD_LAT];
   assign rd_owner = rd_id_sr[RD_LAT];

   // State register.
   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: arbitrate from IDLE; leave BURST on last beat or owner drop.
   always_comb begin
      state_d   = state_q;
      grant_now = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d   = BURST;
               grant_now = 1'b1;
            end
         end
         BURST: begin
            if (!own_req || own_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Grant, owner, per-class pointers and write streak update on each new burst.
   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         gnt         <= '0;
         owner_q     <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         wr_streak_q <= '0;
      end else if (grant_now) begin
         gnt     <= win_oh;
         owner_q <= win_idx;
         if (pick_write) begin
            wr_ptr_q <= IDX_W'(rr_next(int'(wr_pick_idx), NUM_REQ));
            if (!streak_full) begin
               wr_streak_q <= wr_streak_q + 1'b1;
            end
         end else begin
            rd_ptr_q    <= IDX_W'(rr_next(int'(rd_pick_idx), NUM_REQ));
            wr_streak_q <= '0;
         end
      end else if (state_d == IDLE) begin
         gnt <= '0;
      end
   end

   // Buffer controls: capture owner fields on each acked beat; no ack means no write.
   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         mem_frame_num <= '0;
         mem_offset_0  <= '0;
         mem_offset_1  <= '0;
         mem_we        <= 1'b0;
      end else if (beat_ack) begin
         mem_frame_num <= own_frame;
         mem_offset_0  <= own_off_0;
         mem_offset_1  <= own_off_1;
         mem_we        <= own_we;
      end else begin
         mem_we <= 1'b0;
      end
   end

   // Read tag pipeline: owner id follows the address register plus RD_LAT buffer cycles.
   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         rd_vld_sr <= '0;
         for (int i = 0; i <= RD_LAT; i++) begin
            rd_id_sr[i] <= '0;
         end
      end else begin
         rd_vld_sr[0] <= rd_push;
         rd_id_sr[0]  <= rd_push ? owner_q : '0;
         for (int i = 1; i <= RD_LAT; i++) begin
            rd_vld_sr[i] <= rd_vld_sr[i-1];
            rd_id_sr[i]  <= rd_id_sr[i-1];
         end
      end
   end

endmodule

// File: tb/tb_oflow_mem_buffer_arbiter.sv
// Self-checking bench for the buffer arbiter: vector table, corner sequences, random traffic.
// Latency: n/a (simulation only).
// Backpressure: stimulus honours hold-until-last-ack on every requester.
module tb_oflow_mem_buffer_arbiter;

   localparam int N    = 4;
   localparam int FW   = 5;
   localparam int OW   = 7;
   localparam int RL   = 1;
   localparam int MAXS = 3;

   logic                  clk;
   logic                  reset_N;
   logic [N-1:0]          req;
   logic [N-1:0]          req_we;
   logic [N-1:0]          req_last;
   logic [N*FW-1:0]       req_frame;
   logic [N*OW-1:0]       req_offset_0;
   logic [N*OW-1:0]       req_offset_1;
   logic [N-1:0]          gnt;
   logic [N-1:0]          ack;
   logic [FW-1:0]         mem_frame_num;
   logic [OW-1:0]         mem_offset_0;
   logic [OW-1:0]         mem_offset_1;
   logic                  mem_we;
   logic                  rd_valid;
   logic [$clog2(N)-1:0]  rd_owner;
   logic                  busy;

   int checks   = 0;
   int failures = 0;

   oflow_mem_buffer_arbiter #(
      .NUM_REQ(N), .FRAME_W(FW), .OFFSET_W(OW), .RD_LAT(RL), .MAX_WR_STREAK(MAXS)
   ) dut (
      .clk           (clk),
      .reset_N       (reset_N),
      .req           (req),
      .req_we        (req_we),
      .req_frame     (req_frame),
      .req_offset_0  (req_offset_0),
      .req_offset_1  (req_offset_1),
      .req_last      (req_last),
      .gnt           (gnt),
      .ack           (ack),
      .mem_frame_num (mem_frame_num),
      .mem_offset_0  (mem_offset_0),
      .mem_offset_1  (mem_offset_1),
      .mem_we        (mem_we),
      .rd_valid      (rd_valid),
      .rd_owner      (rd_owner),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Same fields presented on every requester.
   task automatic drive(input logic [N-1:0] r, input logic [N-1:0] w, input logic [N-1:0] l,
                        input int fr, input int o0, input int o1);
      req      = r;
      req_we   = w;
      req_last = l;
      for (int i = 0; i < N; i++) begin
         req_frame[i*FW +: FW]    = FW'(fr);
         req_offset_0[i*OW +: OW] = OW'(o0);
         req_offset_1[i*OW +: OW] = OW'(o1);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive('0, '0, '0, 0, 0, 0);
      reset_N = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_N = 1'b1;
      step();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " gnt"}, int'(gnt), 0);
      chk({tag, " ack"}, int'(ack), 0);
      chk({tag, " busy"}, int'(busy), 0);
      chk({tag, " mem_we"}, int'(mem_we), 0);
      chk({tag, " mem_frame"}, int'(mem_frame_num), 0);
      chk({tag, " mem_off0"}, int'(mem_offset_0), 0);
      chk({tag, " mem_off1"}, int'(mem_offset_1), 0);
      chk({tag, " rd_valid"}, int'(rd_valid), 0);
      chk({tag, " rd_owner"}, int'(rd_owner), 0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [N-1:0] req, we, last;
      int           fr, o0, o1;
      logic [N-1:0] e_gnt, e_ack;
      int           e_busy, e_we, e_fr, e_o0, e_o1, e_rv, e_ro;
   } vec_t;

   function automatic vec_t mk(input logic [N-1:0] r, input logic [N-1:0] w, input logic [N-1:0] l,
                               input int fr, input int o0, input int o1,
                               input logic [N-1:0] eg, input logic [N-1:0] ea, input int eb,
                               input int ewe, input int efr, input int eo0, input int eo1,
                               input int erv, input int ero);
      vec_t v;
      v.req = r; v.we = w; v.last = l; v.fr = fr; v.o0 = o0; v.o1 = o1;
      v.e_gnt = eg; v.e_ack = ea; v.e_busy = eb; v.e_we = ewe;
      v.e_fr = efr; v.e_o0 = eo0; v.e_o1 = eo1; v.e_rv = erv; v.e_ro = ero;
      return v;
   endfunction

   // ---------------- reference model ----------------
   int m_busy, m_owner, m_rptr, m_wptr, m_streak;
   int m_fr, m_o0, m_o1, m_we, cyc;
   int ret_due[$];
   int ret_own[$];
   logic [N-1:0] r_req, r_we, r_last;
   int r_fr[N], r_o0[N], r_o1[N];

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_rptr = 0; m_wptr = 0; m_streak = 0;
      m_fr = 0; m_o0 = 0; m_o1 = 0; m_we = 0; cyc = 0;
      ret_due.delete();
      ret_own.delete();
   endtask

   // Compare this cycle's outputs with the model, then advance the model one clock.
   task automatic model_cycle(output logic [N-1:0] e_ack);
      logic [N-1:0] e_gnt, wset, rset, set;
      int e_rv, use_w, p, win, c;
      e_gnt = m_busy != 0 ? (N'(1) << m_owner) : '0;
      e_ack = e_gnt & r_req;
      e_rv  = (ret_due.size() > 0 && ret_due[0] == cyc) ? 1 : 0;
      chk("rnd gnt", int'(gnt), int'(e_gnt));
      chk("rnd ack", int'(ack), int'(e_ack));
      chk("rnd busy", int'(busy), m_busy);
      chk("rnd mem_we", int'(mem_we), m_we);
      chk("rnd mem_frame", int'(mem_frame_num), m_fr);
      chk("rnd mem_off0", int'(mem_offset_0), m_o0);
      chk("rnd mem_off1", int'(mem_offset_1), m_o1);
      chk("rnd rd_valid", int'(rd_valid), e_rv);
      if (e_rv != 0) begin
         chk("rnd rd_owner", int'(rd_owner), ret_own[0]);
         void'(ret_due.pop_front());
         void'(ret_own.pop_front());
      end
      if (m_busy == 0) begin
         m_we = 0;
         if (r_req != '0) begin
            wset  = r_req & r_we;
            rset  = r_req & ~r_we;
            use_w = (wset != '0 && !(m_streak == MAXS && rset != '0)) ? 1 : 0;
            set   = use_w != 0 ? wset : rset;
            p     = use_w != 0 ? m_wptr : m_rptr;
            win   = -1;
            for (int k = 0; k < N; k++) begin
               c = (p + k) % N;
               if (win < 0 && set[c]) win = c;
            end
            if (use_w != 0) begin
               m_wptr   = (win + 1) % N;
               m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
            end else begin
               m_rptr   = (win + 1) % N;
               m_streak = 0;
            end
            m_busy  = 1;
            m_owner = win;
         end
      end else if (r_req[m_owner]) begin
         m_fr = r_fr[m_owner];
         m_o0 = r_o0[m_owner];
         m_o1 = r_o1[m_owner];
         m_we = r_we[m_owner] ? 1 : 0;
         if (!r_we[m_owner]) begin
            ret_due.push_back(cyc + RL + 1);
            ret_own.push_back(m_owner);
         end
         if (r_last[m_owner]) m_busy = 0;
      end else begin
         m_we   = 0;
         m_busy = 0;
      end
      cyc++;
   endtask

   // ---------------- test sequence ----------------
   vec_t tbl[14];
   int   starv_exp[8];
   int   g_act[N], g_we[N], g_left[N];
   logic [N-1:0] e_ack;
   int   exp_g;

   initial begin
      reset_N = 1'b0;
      drive('0, '0, '0, 0, 0, 0);
      #12;
      chk_all_zero("reset");
      do_reset();
      chk_all_zero("after_reset");

      // Single read on req 1, then a 4-beat write racing a read on req 0.
      tbl[0]  = mk(4'b0010, 4'b0000, 4'b0010,  3,  5,  6, 4'b0000, 4'b0000, 0, 0,  0,  0,  0, 0, 0);
      tbl[1]  = mk(4'b0010, 4'b0000, 4'b0010,  3,  5,  6, 4'b0010, 4'b0010, 1, 0,  0,  0,  0, 0, 0);
      tbl[2]  = mk(4'b0000, 4'b0000, 4'b0000,  0,  0,  0, 4'b0000, 4'b0000, 0, 0,  3,  5,  6, 0, 0);
      tbl[3]  = mk(4'b0000, 4'b0000, 4'b0000,  0,  0,  0, 4'b0000, 4'b0000, 0, 0,  3,  5,  6, 1, 1);
      tbl[4]  = mk(4'b0000, 4'b0000, 4'b0000,  0,  0,  0, 4'b0000, 4'b0000, 0, 0,  3,  5,  6, 0, 0);
      tbl[5]  = mk(4'b0101, 4'b0100, 4'b0000,  7, 10, 11, 4'b0000, 4'b0000, 0, 0,  3,  5,  6, 0, 0);
      tbl[6]  = mk(4'b0101, 4'b0100, 4'b0000,  7, 10, 11, 4'b0100, 4'b0100, 1, 0,  3,  5,  6, 0, 0);
      tbl[7]  = mk(4'b0101, 4'b0100, 4'b0000,  8, 12, 13, 4'b0100, 4'b0100, 1, 1,  7, 10, 11, 0, 0);
      tbl[8]  = mk(4'b0101, 4'b0100, 4'b0000,  9, 14, 15, 4'b0100, 4'b0100, 1, 1,  8, 12, 13, 0, 0);
      tbl[9]  = mk(4'b0101, 4'b0100, 4'b0101, 10, 16, 17, 4'b0100, 4'b0100, 1, 1,  9, 14, 15, 0, 0);
      tbl[10] = mk(4'b0001, 4'b0000, 4'b0001, 11, 18, 19, 4'b0000, 4'b0000, 0, 1, 10, 16, 17, 0, 0);
      tbl[11] = mk(4'b0001, 4'b0000, 4'b0001, 11, 18, 19, 4'b0001, 4'b0001, 1, 0, 10, 16, 17, 0, 0);
      tbl[12] = mk(4'b0000, 4'b0000, 4'b0000,  0,  0,  0, 4'b0000, 4'b0000, 0, 0, 11, 18, 19, 0, 0);
      tbl[13] = mk(4'b0000, 4'b0000, 4'b0000,  0,  0,  0, 4'b0000, 4'b0000, 0, 0, 11, 18, 19, 1, 0);

      for (int r = 0; r < 14; r++) begin
         drive(tbl[r].req, tbl[r].we, tbl[r].last, tbl[r].fr, tbl[r].o0, tbl[r].o1);
         #1;
         chk($sformatf("row%0d gnt", r), int'(gnt), int'(tbl[r].e_gnt));
         chk($sformatf("row%0d ack", r), int'(ack), int'(tbl[r].e_ack));
         chk($sformatf("row%0d busy", r), int'(busy), tbl[r].e_busy);
         chk($sformatf("row%0d mem_we", r), int'(mem_we), tbl[r].e_we);
         chk($sformatf("row%0d mem_frame", r), int'(mem_frame_num), tbl[r].e_fr);
         chk($sformatf("row%0d mem_off0", r), int'(mem_offset_0), tbl[r].e_o0);
         chk($sformatf("row%0d mem_off1", r), int'(mem_offset_1), tbl[r].e_o1);
         chk($sformatf("row%0d rd_valid", r), int'(rd_valid), tbl[r].e_rv);
         if (tbl[r].e_rv != 0) chk($sformatf("row%0d rd_owner", r), int'(rd_owner), tbl[r].e_ro);
         step();
      end

      // Fairness: four held 1-beat reads rotate 0,1,2,3,0 with an IDLE cycle between.
      do_reset();
      drive(4'b1111, 4'b0000, 4'b1111, 1, 2, 3);
      for (int k = 0; k < 10; k++) begin
         #1;
         exp_g = (k % 2 == 1) ? (1 << (((k - 1) / 2) % N)) : 0;
         chk($sformatf("fair%0d gnt", k), int'(gnt), exp_g);
         chk($sformatf("fair%0d busy", k), int'(busy), k % 2);
         step();
      end

      // Starvation guard: writes on 1 and 3 yield to the read on 0 after three bursts.
      do_reset();
      starv_exp = '{2, 8, 2, 1, 8, 2, 8, 1};
      drive(4'b1011, 4'b1010, 4'b1011, 2, 4, 6);
      for (int k = 0; k < 16; k++) begin
         #1;
         exp_g = (k % 2 == 1) ? starv_exp[(k - 1) / 2] : 0;
         chk($sformatf("starv%0d gnt", k), int'(gnt), exp_g);
         if (k == 2) chk("starv2 mem_we", int'(mem_we), 1);
         if (k == 8) chk("starv8 mem_we", int'(mem_we), 0);
         if (k == 9) begin
            chk("starv9 rd_valid", int'(rd_valid), 1);
            chk("starv9 rd_owner", int'(rd_owner), 0);
         end
         step();
      end

      // Abort: req 2 drops after two beats without last.
      do_reset();
      drive(4'b0100, 4'b0100, 4'b0000, 4, 20, 21);
      #1 chk("abort0 gnt", int'(gnt), 0);
      step();
      drive(4'b0100, 4'b0100, 4'b0000, 5, 22, 23);
      #1 chk("abort1 ack", int'(ack), 4'b0100);
      step();
      drive(4'b0100, 4'b0100, 4'b0000, 6, 24, 25);
      #1 chk("abort2 ack", int'(ack), 4'b0100);
      chk("abort2 mem_frame", int'(mem_frame_num), 5);
      step();
      drive(4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
      #1 chk("abort3 ack", int'(ack), 0);
      chk("abort3 gnt", int'(gnt), 4'b0100);
      chk("abort3 busy", int'(busy), 1);
      chk("abort3 mem_we", int'(mem_we), 1);
      step();
      #1 chk("abort4 gnt", int'(gnt), 0);
      chk("abort4 busy", int'(busy), 0);
      chk("abort4 mem_we", int'(mem_we), 0);
      chk("abort4 mem_frame", int'(mem_frame_num), 6);
      chk("abort4 mem_off0", int'(mem_offset_0), 24);
      step();

      // Reset during beat 2 of a write burst.
      do_reset();
      drive(4'b0010, 4'b0010, 4'b0000, 9, 30, 31);
      step();
      #1 chk("rstmid1 ack", int'(ack), 4'b0010);
      step();
      #1 chk("rstmid2 mem_we", int'(mem_we), 1);
      reset_N = 1'b0;
      #1;
      chk_all_zero("rstmid_assert");
      drive('0, '0, '0, 0, 0, 0);
      @(posedge clk);
      #1 reset_N = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk_all_zero($sformatf("rstmid_idle%0d", k));
      end

      // Random traffic against the reference model.
      do_reset();
      model_reset();
      for (int i = 0; i < N; i++) begin
         g_act[i] = 0; g_we[i] = 0; g_left[i] = 0;
      end
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (g_act[i] == 0) begin
               if ($urandom_range(0, 3) == 0) begin
                  g_act[i]  = 1;
                  g_we[i]   = int'($urandom_range(0, 1));
                  g_left[i] = int'($urandom_range(1, 4));
               end
            end else if ($urandom_range(0, 39) == 0) begin
               g_act[i] = 0;
            end
            r_req[i]  = (g_act[i] != 0);
            r_we[i]   = (g_act[i] != 0) && (g_we[i] != 0);
            r_last[i] = (g_act[i] != 0) && (g_left[i] == 1);
            r_fr[i]   = int'($urandom_range(0, 31));
            r_o0[i]   = int'($urandom_range(0, 127));
            r_o1[i]   = int'($urandom_range(0, 127));
            req_frame[i*FW +: FW]    = FW'(r_fr[i]);
            req_offset_0[i*OW +: OW] = OW'(r_o0[i]);
            req_offset_1[i*OW +: OW] = OW'(r_o1[i]);
         end
         req      = r_req;
         req_we   = r_we;
         req_last = r_last;
         #1;
         model_cycle(e_ack);
         for (int i = 0; i < N; i++) begin
            if (e_ack[i]) begin
               g_left[i]--;
               if (g_left[i] == 0) g_act[i] = 0;
            end
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
